// File: rtl/bcd_converter_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// controller state encoding and the double-dabble adjust constants.
package bcd_converter_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // A digit at or above this value would exceed 9 after doubling,
    // so it is pre-corrected by adding ADD3_VALUE before the shift.
    localparam logic [3:0] ADD3_THRESH = 4'd5;
    localparam logic [3:0] ADD3_VALUE  = 4'd3;

endpackage

// File: rtl/bcd_converter_seq_if.sv
// Request/response bundle of the BCD converter. The master side is the
// producer/consumer pair; the slave side is the converter itself.
interface bcd_converter_seq_if #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
);
    logic                in_valid;
    logic                in_ready;
    logic [WIDTH-1:0]    bin;
    logic                out_valid;
    logic                out_ready;
    logic [4*DIGITS-1:0] bcd;
    logic                neg;
    logic                ovf;

    modport master (
        output in_valid, bin, out_ready,
        input  in_ready, out_valid, bcd, neg, ovf
    );

    modport slave (
        input  in_valid, bin, out_ready,
        output in_ready, out_valid, bcd, neg, ovf
    );
endinterface

// File: rtl/bcd_converter_seq_cell.sv
// One BCD digit of the double-dabble chain: conditionally add 3, then
// shift left by one, taking cin into bit 0 and passing bit 3 out as cout.
module bcd_digit_cell
    import bcd_converter_seq_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       cin,
    output logic [3:0] digit_nxt,
    output logic       cout
);
    logic [3:0] adj;

    // Pre-correct the digit so the following doubling carries decimally.
    always_comb begin
        adj = digit;
        if (digit >= ADD3_THRESH) begin
            adj = digit + ADD3_VALUE;
        end
    end

    assign digit_nxt = {adj[2:0], cin};
    assign cout      = adj[3];
endmodule

// File: rtl/bcd_converter_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3). One operand bit is
// consumed per cycle MSB-first; the result is held until the consumer
// takes it. Bits shifted out of the top digit flag overflow.
module bcd_converter_seq
    import bcd_converter_seq_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int DIGITS      = 5,
    parameter bit SIGNED_MODE = 1'b0
) (
    input logic              clk,
    input logic              rst_n,
    bcd_converter_seq_if.slave bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);

    state_t              state;
    logic [WIDTH-1:0]    opnd;
    logic [4*DIGITS-1:0] digits_q;
    logic [4*DIGITS-1:0] digits_nxt;
    logic [DIGITS:0]     carry;
    logic [CNT_W-1:0]    cnt;
    logic                neg_q;
    logic                ovf_q;
    logic                in_ready_q;
    logic                out_valid_q;

    // Magnitude of the operand; the most negative value maps to 2^(WIDTH-1),
    // which still fits in WIDTH unsigned bits.
    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
        logic signed [WIDTH-1:0] n;
        n = -v;
        if (SIGNED_MODE && (v < 0)) begin
            return $unsigned(n);
        end
        return $unsigned(v);
    endfunction

    assign carry[0] = opnd[WIDTH-1];

    for (genvar g = 0; g < DIGITS; g++) begin : g_cell
        bcd_digit_cell u_cell (
            .digit     (digits_q[4*g +: 4]),
            .cin       (carry[g]),
            .digit_nxt (digits_nxt[4*g +: 4]),
            .cout      (carry[g+1])
        );
    end

    // Controller and datapath registers: capture, WIDTH shift steps, hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            opnd        <= '0;
            digits_q    <= '0;
            cnt         <= '0;
            neg_q       <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        opnd       <= magnitude($signed(bus.bin));
                        neg_q      <= SIGNED_MODE && bus.bin[WIDTH-1];
                        digits_q   <= '0;
                        ovf_q      <= 1'b0;
                        cnt        <= CNT_LOAD;
                        in_ready_q <= 1'b0;
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    digits_q <= digits_nxt;
                    opnd     <= {opnd[WIDTH-2:0], 1'b0};
                    if (carry[DIGITS]) begin
                        ovf_q <= 1'b1;
                    end
                    if (cnt == '0) begin
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.bcd       = digits_q;
    assign bus.neg       = neg_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_bcd_converter_seq.sv
// Bench for bcd_converter_seq: three instances (default, 4 digits, signed)
// driven by the same request stream and compared against hand-written
// vectors and an arithmetic reference model.
module tb_bcd_converter_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] bin = 16'd0;

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int acc_cyc[$];

    bcd_converter_seq_if #(.WIDTH(16), .DIGITS(5)) ia ();
    bcd_converter_seq_if #(.WIDTH(16), .DIGITS(4)) ib ();
    bcd_converter_seq_if #(.WIDTH(16), .DIGITS(5)) ic ();

    assign ia.in_valid = in_valid;
    assign ib.in_valid = in_valid;
    assign ic.in_valid = in_valid;
    assign ia.bin = bin;
    assign ib.bin = bin;
    assign ic.bin = bin;
    assign ia.out_ready = out_ready;
    assign ib.out_ready = out_ready;
    assign ic.out_ready = out_ready;

    bcd_converter_seq #(.WIDTH(16), .DIGITS(5), .SIGNED_MODE(1'b0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
    bcd_converter_seq #(.WIDTH(16), .DIGITS(4), .SIGNED_MODE(1'b0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));
    bcd_converter_seq #(.WIDTH(16), .DIGITS(5), .SIGNED_MODE(1'b1)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ic));

    always #5 clk = ~clk;

    // Cycle counter and log of the cycles on which dut_a accepted a request.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ia.in_valid && ia.in_ready) acc_cyc.push_back(cyc);
    end

    // Hard stop in case something never returns.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [15:0] bin;
        logic [19:0] bcd5;
        logic        ovf5;
        logic [15:0] bcd4;
        logic        ovf4;
        logic        neg_s;
        logic [19:0] bcd_s;
        logic        ovf_s;
    } vec_t;

    typedef struct packed {
        logic [39:0] bcd;
        logic        neg;
        logic        ovf;
    } res_t;

    vec_t vt[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Decimal digits by division, overflow by comparing against 10^nd.
    function automatic res_t model(input logic [15:0] b, input int nd, input bit sgn);
        res_t   r;
        longint mag;
        longint p;
        r   = '0;
        mag = longint'(b);
        if (sgn && b[15]) begin
            r.neg = 1'b1;
            mag   = 65536 - mag;
        end
        p = 1;
        for (int i = 0; i < nd; i++) begin
            r.bcd[4*i +: 4] = 4'((mag / p) % 10);
            p = p * 10;
        end
        r.ovf = (mag >= p);
        return r;
    endfunction

    task automatic wait_valid(output int n);
        n = 0;
        while (!ia.out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    // Issue one request with out_ready high; lat counts edges from the
    // accepting edge (as 1) until out_valid is seen.
    task automatic convert(input logic [15:0] b, output int lat);
        in_valid = 1'b1;
        bin      = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!ia.out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " a.bcd"}, ia.bcd, 0);
        chk({tag, " b.bcd"}, ib.bcd, 0);
        chk({tag, " c.bcd"}, ic.bcd, 0);
        chk({tag, " a.out_valid"}, ia.out_valid, 0);
        chk({tag, " c.neg"}, ic.neg, 0);
        chk({tag, " a.ovf"}, ia.ovf, 0);
        chk({tag, " b.ovf"}, ib.ovf, 0);
    endtask

    initial begin
        int   lat;
        int   n;
        int   n_acc;
        res_t ea, eb, ec;
        logic [15:0] rb;

        vt[0] = '{16'd841,   20'h00841, 1'b0, 16'h0841, 1'b0, 1'b0, 20'h00841, 1'b0};
        vt[1] = '{16'd65535, 20'h65535, 1'b0, 16'h5535, 1'b1, 1'b1, 20'h00001, 1'b0};
        vt[2] = '{16'd0,     20'h00000, 1'b0, 16'h0000, 1'b0, 1'b0, 20'h00000, 1'b0};
        vt[3] = '{16'd12345, 20'h12345, 1'b0, 16'h2345, 1'b1, 1'b0, 20'h12345, 1'b0};
        vt[4] = '{16'h8000,  20'h32768, 1'b0, 16'h2768, 1'b1, 1'b1, 20'h32768, 1'b0};
        vt[5] = '{16'd9999,  20'h09999, 1'b0, 16'h9999, 1'b0, 1'b0, 20'h09999, 1'b0};
        vt[6] = '{16'd10000, 20'h10000, 1'b0, 16'h0000, 1'b1, 1'b0, 20'h10000, 1'b0};
        vt[7] = '{16'h7FFF,  20'h32767, 1'b0, 16'h2767, 1'b1, 1'b0, 20'h32767, 1'b0};
        vt[8] = '{16'hFC18,  20'h64536, 1'b0, 16'h4536, 1'b1, 1'b1, 20'h01000, 1'b0};

        // Reset state
        #12;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset in_ready", ia.in_ready, 1);

        // Table vectors
        for (int i = 0; i < 9; i++) begin
            convert(vt[i].bin, lat);
            chk($sformatf("vec%0d latency", i), lat, 17);
            chk($sformatf("vec%0d b.out_valid", i), ib.out_valid, 1);
            chk($sformatf("vec%0d c.out_valid", i), ic.out_valid, 1);
            chk($sformatf("vec%0d in_ready", i), ia.in_ready, 0);
            chk($sformatf("vec%0d a.bcd", i), ia.bcd, vt[i].bcd5);
            chk($sformatf("vec%0d a.ovf", i), ia.ovf, vt[i].ovf5);
            chk($sformatf("vec%0d a.neg", i), ia.neg, 0);
            chk($sformatf("vec%0d b.bcd", i), ib.bcd, vt[i].bcd4);
            chk($sformatf("vec%0d b.ovf", i), ib.ovf, vt[i].ovf4);
            chk($sformatf("vec%0d c.bcd", i), ic.bcd, vt[i].bcd_s);
            chk($sformatf("vec%0d c.neg", i), ic.neg, vt[i].neg_s);
            chk($sformatf("vec%0d c.ovf", i), ic.ovf, vt[i].ovf_s);
            @(posedge clk); #1;
        end

        // Random operands against the reference model
        for (int i = 0; i < 150; i++) begin
            rb = 16'($urandom);
            ea = model(rb, 5, 1'b0);
            eb = model(rb, 4, 1'b0);
            ec = model(rb, 5, 1'b1);
            convert(rb, lat);
            chk($sformatf("rnd%0d latency", i), lat, 17);
            chk($sformatf("rnd%0d a.bcd bin=%0d", i, rb), ia.bcd, ea.bcd[19:0]);
            chk($sformatf("rnd%0d a.ovf", i), ia.ovf, ea.ovf);
            chk($sformatf("rnd%0d b.bcd bin=%0d", i, rb), ib.bcd, eb.bcd[15:0]);
            chk($sformatf("rnd%0d b.ovf", i), ib.ovf, eb.ovf);
            chk($sformatf("rnd%0d c.bcd bin=%0h", i, rb), ic.bcd, ec.bcd[19:0]);
            chk($sformatf("rnd%0d c.neg", i), ic.neg, ec.neg);
            chk($sformatf("rnd%0d c.ovf", i), ic.ovf, ec.ovf);
            @(posedge clk); #1;
        end

        // Back-to-back: 65535 then 0 with in_valid held high
        acc_cyc.delete();
        in_valid = 1'b1;
        bin      = 16'd65535;
        wait_valid(n);
        chk("b2b first valid", ia.out_valid, 1);
        chk("b2b first bcd", ia.bcd, 20'h65535);
        bin = 16'd0;
        n = 0;
        while (acc_cyc.size() < 2 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        chk("b2b accept gap", (acc_cyc.size() >= 2) ? (acc_cyc[1] - acc_cyc[0]) : -1, 18);
        wait_valid(n);
        chk("b2b second valid", ia.out_valid, 1);
        chk("b2b second bcd", ia.bcd, 20'h00000);
        chk("b2b second ovf", ia.ovf, 0);
        @(posedge clk); #1;

        // Consumer stalls for 10 cycles while a new request is offered
        out_ready = 1'b0;
        in_valid  = 1'b1;
        bin       = 16'd841;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_valid(n);
        chk("stall valid", ia.out_valid, 1);
        in_valid = 1'b1;
        bin      = 16'd1234;
        n_acc    = acc_cyc.size();
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            chk($sformatf("stall%0d out_valid", k), ia.out_valid, 1);
            chk($sformatf("stall%0d in_ready", k), ia.in_ready, 0);
            chk($sformatf("stall%0d bcd", k), ia.bcd, 20'h00841);
        end
        chk("stall no accept", acc_cyc.size(), n_acc);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("stall release out_valid", ia.out_valid, 0);
        chk("stall release in_ready", ia.in_ready, 1);

        // Reset asserted during the shift phase
        in_valid = 1'b1;
        bin      = 16'hFFFF;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_zero("midreset");
        chk("midreset in_ready", ia.in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        convert(16'd841, lat);
        chk("post-reset latency", lat, 17);
        chk("post-reset a.bcd", ia.bcd, 20'h00841);
        chk("post-reset b.bcd", ib.bcd, 16'h0841);
        chk("post-reset c.bcd", ic.bcd, 20'h00841);
        chk("post-reset c.neg", ic.neg, 0);
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/bcd_converter_seq.md
BCD_CONVERTER_SEQ -- requirements
Module: bcd_converter_seq

Interface
REQ-001 Parameter WIDTH, default 16: binary input width, legal range 4..32.
REQ-002 Parameter DIGITS, default 5: number of BCD output digits, legal range 1..10.
REQ-003 Parameter SIGNED_MODE, default 0: 0 treats bin as unsigned; 1 treats bin as two's complement.
REQ-004 Port clk  input  1: the single clock; all state updates on the rising edge.
REQ-005 Port rst_n  input  1: asynchronous, active-low reset.
REQ-006 Port in_valid  input  1: bin holds a request.
REQ-007 Port in_ready  output  1: block accepts a request.
REQ-008 Port bin  input  WIDTH: binary value to convert.
REQ-009 Port out_valid  output  1: result is presented.
REQ-010 Port out_ready  input  1: consumer takes the result.
REQ-011 Port bcd  output  4*DIGITS: packed digits, digit 0 (ones) in bits [3:0], ascending significance.
REQ-012 Port neg  output  1: result sign; constant 0 when SIGNED_MODE=0.
REQ-013 Port ovf  output  1: magnitude exceeds 10^DIGITS-1; bcd then holds the low DIGITS digits.

Function
REQ-014 FSM states SHALL be IDLE, SHIFT and DONE.
REQ-015 IDLE: in_ready=1, out_valid=0; in_valid=1 captures the operand, clears the digit registers and ovf, loads the bit counter with WIDTH-1, and enters SHIFT.
REQ-016 Operand capture with SIGNED_MODE=1 SHALL store the magnitude and the sign bit into neg; -2^(WIDTH-1) yields magnitude 2^(WIDTH-1) with no loss.
REQ-017 SHIFT: each cycle, every digit >=5 gets +3, then the digit chain shifts left one bit, taking the next operand bit MSB-first into digit 0 bit 0.
REQ-018 SHIFT: a 1 shifted out of the top digit bit 3 SHALL set ovf sticky for the conversion.
REQ-019 SHIFT: after exactly WIDTH shift cycles the FSM enters DONE.
REQ-020 Latency: out_valid SHALL rise WIDTH+1 cycles after the accepting edge.
REQ-021 DONE: out_valid=1; bcd, neg and ovf stay stable until out_ready=1, which returns the FSM to IDLE.
REQ-022 in_ready SHALL be 0 in SHIFT and DONE; in_valid there is ignored and no operand is dropped silently, because the producer holds it.
REQ-023 No combinational path SHALL exist from in_valid to in_ready or from out_ready to out_valid.
REQ-024 Back-to-back throughput SHALL be one conversion per WIDTH+2 cycles.
REQ-025 Every digit of bcd SHALL lie in 0..9 in DONE.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, in_ready=1 after release, out_valid=0, bcd=0, neg=0, ovf=0 and counter=0, including mid-SHIFT or mid-DONE; the partial result is discarded.
REQ-027 The first accept after rst_n is deasserted SHALL occur no earlier than the first rising clk edge.

Structure
REQ-028 A shared package SHALL hold the FSM state enumeration and the add-3 threshold constants.
REQ-029 One sub-module, bcd_digit_cell (a 4-bit adjust/shift cell with carry in and out), SHALL be instantiated DIGITS times.

Verification
REQ-030 Defaults, bin=841, out_ready=1: out_valid after 17 cycles, bcd=20'h00841, ovf=0.
REQ-031 Defaults, bin=65535 followed by bin=0 back-to-back: bcd=20'h65535, then bcd=20'h00000, with the second accept 18 cycles after the first.
REQ-032 DIGITS=4, bin=12345: bcd=16'h2345, ovf=1.
REQ-033 SIGNED_MODE=1, bin=16'h8000 and then 16'hFFFF: neg=1 with bcd=20'h32768, then neg=1 with bcd=20'h00001.
REQ-034 out_ready held 0 for 10 cycles in DONE: bcd is stable, in_ready=0, and a new in_valid is not accepted.
REQ-035 rst_n pulsed low at SHIFT cycle 7: outputs zero at once, state IDLE, and the next conversion of 841 is correct.
